// File: rtl/mac_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mac_pkg
//  Description : Shared types and helpers for the pipelined MAC datapath:
//                pipeline width helpers, saturation limits, stage control.
//  Revision    : 1.0 - initial release
// ============================================================================
package mac_pkg;

    // Widest accumulator the saturation helpers can describe.
    localparam int MAX_ACC_W = 128;

    // Half operand width: each partial product is HALF x HALF bits.
    function automatic int half_w(input int width);
        return width / 2;
    endfunction

    // Full product width before extension to the accumulator.
    function automatic int prod_w(input int width);
        return 2 * width;
    endfunction

    // Largest representable accumulator value in the low w bits.
    function automatic logic [MAX_ACC_W-1:0] sat_max(input logic is_signed, input int w);
        logic [MAX_ACC_W-1:0] r;
        r = '0;
        for (int i = 0; i < MAX_ACC_W; i++) begin
            if ((i < w - 1) || (!is_signed && (i == w - 1))) begin
                r[i] = 1'b1;
            end
        end
        return r;
    endfunction

    // Smallest representable accumulator value in the low w bits.
    function automatic logic [MAX_ACC_W-1:0] sat_min(input logic is_signed, input int w);
        logic [MAX_ACC_W-1:0] r;
        r = '0;
        for (int i = 0; i < MAX_ACC_W; i++) begin
            if (is_signed && (i == w - 1)) begin
                r[i] = 1'b1;
            end
        end
        return r;
    endfunction

    // Control fields travelling alongside the data through each stage.
    typedef struct packed {
        logic valid;
        logic is_signed;
        logic sign;
        logic clr;
    } stage_ctrl_t;

endpackage
`default_nettype wire

// File: rtl/mac_half_mult.sv
`default_nettype none
// ============================================================================
//  Module      : mac_half_mult
//  Description : Unsigned W x W combinational multiplier producing a 2W-bit
//                partial product for the MAC pipeline.
//  Revision    : 1.0 - initial release
// ============================================================================
module mac_half_mult #(
    parameter int W = 8
) (
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic [2*W-1:0] p
);

    // Zero-extend both operands so the multiply is evaluated at full width.
    assign p = {{W{1'b0}}, a} * {{W{1'b0}}, b};

endmodule
`default_nettype wire

// File: rtl/mac_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : mac_pipe
//  Description : Three-stage pipelined multiply-accumulate with signed/unsigned
//                beats, accumulate/clear control, optional saturation, sticky
//                overflow and a valid/ready handshake with global stall.
//  Revision    : 1.0 - initial release
// ============================================================================
module mac_pipe
    import mac_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int ACC_WIDTH = 40,
    parameter int SATURATE  = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [WIDTH-1:0]     in_b,
    input  logic                 in_signed,
    input  logic                 in_clr,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ACC_WIDTH-1:0] out_acc,
    output logic                 out_ovf
);

    localparam int HALF   = half_w(WIDTH);
    localparam int PROD_W = prod_w(WIDTH);

    // Pipeline state
    logic [WIDTH-1:0]     a_mag_d, a_mag_q;
    logic [WIDTH-1:0]     b_mag_d, b_mag_q;
    stage_ctrl_t          ctrl1_d, ctrl1_q;
    logic [2*HALF-1:0]    ll_d, ll_q, hl_d, hl_q, lh_d, lh_q, hh_d, hh_q;
    stage_ctrl_t          ctrl2_d, ctrl2_q;
    logic [ACC_WIDTH-1:0] acc_d, acc_q;
    logic                 ovf_d, ovf_q;
    logic                 out_valid_d, out_valid_q;

    // Stage 3 combinational datapath
    logic                 advance;
    logic [PROD_W-1:0]    mag;
    logic [PROD_W-1:0]    prod;
    logic                 ext_bit;
    logic [ACC_WIDTH-1:0] prod_ext;
    logic [ACC_WIDTH:0]   sum;
    logic                 ovf_now;
    logic [MAX_ACC_W-1:0] sat_hi_full;
    logic [MAX_ACC_W-1:0] sat_lo_full;

    // The whole pipe moves together; the output register is the only stall point.
    assign advance   = !out_valid_q || out_ready;
    assign in_ready  = advance;
    assign out_valid = out_valid_q;
    assign out_acc   = acc_q;
    assign out_ovf   = ovf_q;

    // S1: capture control and convert signed operands to magnitude + sign.
    always_comb begin
        ctrl1_d = ctrl1_q;
        a_mag_d = a_mag_q;
        b_mag_d = b_mag_q;
        if (advance) begin
            ctrl1_d.valid     = in_valid;
            ctrl1_d.is_signed = in_signed;
            ctrl1_d.sign      = in_signed & (in_a[WIDTH-1] ^ in_b[WIDTH-1]);
            ctrl1_d.clr       = in_clr;
            // -2^(WIDTH-1) negates to itself, which reads correctly as an unsigned magnitude.
            a_mag_d = (in_signed && in_a[WIDTH-1]) ? -in_a : in_a;
            b_mag_d = (in_signed && in_b[WIDTH-1]) ? -in_b : in_b;
        end
    end

    mac_half_mult #(.W(HALF)) u_mul_ll (.a(a_mag_q[HALF-1:0]),     .b(b_mag_q[HALF-1:0]),     .p(ll_d));
    mac_half_mult #(.W(HALF)) u_mul_hl (.a(a_mag_q[WIDTH-1:HALF]), .b(b_mag_q[HALF-1:0]),     .p(hl_d));
    mac_half_mult #(.W(HALF)) u_mul_lh (.a(a_mag_q[HALF-1:0]),     .b(b_mag_q[WIDTH-1:HALF]), .p(lh_d));
    mac_half_mult #(.W(HALF)) u_mul_hh (.a(a_mag_q[WIDTH-1:HALF]), .b(b_mag_q[WIDTH-1:HALF]), .p(hh_d));

    // S2: pass control forward alongside the four partial products.
    always_comb begin
        ctrl2_d = ctrl2_q;
        if (advance) begin
            ctrl2_d = ctrl1_q;
        end
    end

    // S3 combine: recombine partial products and apply the sign.
    always_comb begin
        mag = PROD_W'(ll_q)
            + (PROD_W'(hl_q) << HALF)
            + (PROD_W'(lh_q) << HALF)
            + (PROD_W'(hh_q) << (2 * HALF));
        prod    = ctrl2_q.sign ? -mag : mag;
        ext_bit = ctrl2_q.is_signed & prod[PROD_W-1];
    end

    // Signed beats sign-extend the product, unsigned beats zero-extend it.
    generate
        if (ACC_WIDTH > PROD_W) begin : g_ext_pad
            assign prod_ext = {{(ACC_WIDTH-PROD_W){ext_bit}}, prod};
        end else begin : g_ext_none
            assign prod_ext = prod;
        end
    endgenerate

    // S3 accumulate: add, detect overflow in the beat's own mode, clamp or wrap.
    always_comb begin
        sum         = {1'b0, acc_q} + {1'b0, prod_ext};
        sat_hi_full = sat_max(ctrl2_q.is_signed, ACC_WIDTH);
        sat_lo_full = sat_min(ctrl2_q.is_signed, ACC_WIDTH);
        if (ctrl2_q.is_signed) begin
            ovf_now = (acc_q[ACC_WIDTH-1] == prod_ext[ACC_WIDTH-1])
                   && (sum[ACC_WIDTH-1] != acc_q[ACC_WIDTH-1]);
        end else begin
            ovf_now = sum[ACC_WIDTH];
        end

        acc_d       = acc_q;
        ovf_d       = ovf_q;
        out_valid_d = out_valid_q;
        if (advance) begin
            out_valid_d = ctrl2_q.valid;
            if (ctrl2_q.valid) begin
                if (ctrl2_q.clr) begin
                    acc_d = prod_ext;
                    ovf_d = 1'b0;
                end else begin
                    ovf_d = ovf_q | ovf_now;
                    if (ovf_now && (SATURATE != 0)) begin
                        // Signed overflow only happens with equal-sign addends, so
                        // the accumulator's sign tells which rail was crossed.
                        if (ctrl2_q.is_signed && acc_q[ACC_WIDTH-1]) begin
                            acc_d = sat_lo_full[ACC_WIDTH-1:0];
                        end else begin
                            acc_d = sat_hi_full[ACC_WIDTH-1:0];
                        end
                    end else begin
                        acc_d = sum[ACC_WIDTH-1:0];
                    end
                end
            end
        end
    end

    // State registers for all three stages; reset discards every in-flight beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_mag_q     <= '0;
            b_mag_q     <= '0;
            ctrl1_q     <= '0;
            ll_q        <= '0;
            hl_q        <= '0;
            lh_q        <= '0;
            hh_q        <= '0;
            ctrl2_q     <= '0;
            acc_q       <= '0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            a_mag_q     <= a_mag_d;
            b_mag_q     <= b_mag_d;
            ctrl1_q     <= ctrl1_d;
            ctrl2_q     <= ctrl2_d;
            acc_q       <= acc_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
            if (advance) begin
                ll_q <= ll_d;
                hl_q <= hl_d;
                lh_q <= lh_d;
                hh_q <= hh_d;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mac_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mac_pipe
//  Description : Self-checking bench for mac_pipe: vector table, scoreboard
//                with reference model, backpressure, saturation and reset.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_mac_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_signed, in_clr, out_ready;
    logic [15:0] in_a, in_b;

    logic        in_ready, out_valid, out_ovf;
    logic [39:0] out_acc;
    logic        s_in_ready, s_out_valid, s_out_ovf;
    logic [31:0] s_out_acc;
    logic        w_in_ready, w_out_valid, w_out_ovf;
    logic [31:0] w_out_acc;

    always #5 clk = ~clk;

    mac_pipe #(.WIDTH(16), .ACC_WIDTH(40), .SATURATE(1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_signed(in_signed), .in_clr(in_clr),
        .out_valid(out_valid), .out_ready(out_ready), .out_acc(out_acc), .out_ovf(out_ovf));

    mac_pipe #(.WIDTH(16), .ACC_WIDTH(32), .SATURATE(1)) dut_sat (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s_in_ready),
        .in_a(in_a), .in_b(in_b), .in_signed(in_signed), .in_clr(in_clr),
        .out_valid(s_out_valid), .out_ready(out_ready), .out_acc(s_out_acc), .out_ovf(s_out_ovf));

    mac_pipe #(.WIDTH(16), .ACC_WIDTH(32), .SATURATE(0)) dut_wrap (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(w_in_ready),
        .in_a(in_a), .in_b(in_b), .in_signed(in_signed), .in_clr(in_clr),
        .out_valid(w_out_valid), .out_ready(out_ready), .out_acc(w_out_acc), .out_ovf(w_out_ovf));

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        total++;
        bad++;
        $display("FAIL %s: got=event expected=none", name);
    endtask

    // ---------------- reference model + scoreboard ----------------
    typedef struct {
        logic [39:0] acc;
        logic        ovf;
        bit          has_tbl;
        logic [39:0] tacc;
        logic        tovf;
    } exp_t;

    exp_t        sb_q[$];
    logic [39:0] m_acc = '0;
    logic        m_ovf = 1'b0;
    bit          cur_has_tbl = 0;
    logic [39:0] cur_tacc = '0;
    logic        cur_tovf = 1'b0;

    localparam longint MAXS  = (64'sd1 <<< 39) - 64'sd1;
    localparam longint MINS  = -(64'sd1 <<< 39);
    localparam longint LIM_U = 64'sd1 <<< 40;

    task automatic model_beat(input logic [15:0] a, input logic [15:0] b, input logic sg, input logic cl);
        longint sa, sb, p, s;
        exp_t   e;
        sa = sg ? longint'($signed(a)) : longint'(a);
        sb = sg ? longint'($signed(b)) : longint'(b);
        p  = sa * sb;
        if (cl) begin
            m_acc = p[39:0];
            m_ovf = 1'b0;
        end else if (sg) begin
            s = longint'($signed(m_acc)) + p;
            if (s > MAXS) begin
                m_acc = 40'h7F_FFFF_FFFF; m_ovf = 1'b1;
            end else if (s < MINS) begin
                m_acc = 40'h80_0000_0000; m_ovf = 1'b1;
            end else begin
                m_acc = s[39:0];
            end
        end else begin
            s = longint'(m_acc) + p;
            if (s >= LIM_U) begin
                m_acc = 40'hFF_FFFF_FFFF; m_ovf = 1'b1;
            end else begin
                m_acc = s[39:0];
            end
        end
        e.acc = m_acc; e.ovf = m_ovf;
        e.has_tbl = cur_has_tbl; e.tacc = cur_tacc; e.tovf = cur_tovf;
        sb_q.push_back(e);
    endtask

    logic [31:0] sat_q[$], wrap_q[$];
    logic        sat_ovf_q[$], wrap_ovf_q[$];
    bit          stall_prev = 0;
    logic [39:0] stall_acc = '0;

    // Monitor: sample away from the rising edge, model accepted beats, check results.
    always @(negedge clk) begin
        if (!rst_n) begin
            sb_q.delete();
            m_acc = '0;
            m_ovf = 1'b0;
            stall_prev = 0;
        end else begin
            if (stall_prev) begin
                check("stall_valid_hold", out_valid, 1);
                check("stall_acc_hold", out_acc, stall_acc);
            end
            stall_prev = out_valid && !out_ready;
            stall_acc  = out_acc;
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    fail_now("unexpected_output");
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    check("sb_acc", out_acc, e.acc);
                    check("sb_ovf", out_ovf, e.ovf);
                    if (e.has_tbl) begin
                        check("tbl_acc", out_acc, e.tacc);
                        check("tbl_ovf", out_ovf, e.tovf);
                    end
                end
            end
            if (in_valid && in_ready) model_beat(in_a, in_b, in_signed, in_clr);
            if (s_out_valid && out_ready) begin sat_q.push_back(s_out_acc);  sat_ovf_q.push_back(s_out_ovf);  end
            if (w_out_valid && out_ready) begin wrap_q.push_back(w_out_acc); wrap_ovf_q.push_back(w_out_ovf); end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic send_beat(input logic [15:0] a, input logic [15:0] b, input logic sg, input logic cl);
        int n = 0;
        in_a = a; in_b = b; in_signed = sg; in_clr = cl; in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) fail_now("send_timeout");
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb_q.size() != 0 && n < 60) begin
            @(posedge clk);
            #1 n++;
        end
        check("drain_empty", sb_q.size(), 0);
    endtask

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        sg;
        logic        cl;
        logic [39:0] exp_acc;
        logic        exp_ovf;
    } vec_t;

    vec_t tbl[11];

    initial begin
        int lat;
        int stale;
        bit rnd_done;
        logic [31:0] sat_exp[8], wrap_exp[8];
        logic        sat_oexp[8], wrap_oexp[8];

        tbl[0]  = '{16'hFFFF, 16'hFFFF, 1'b0, 1'b1, 40'h00_FFFE_0001, 1'b0};
        tbl[1]  = '{16'hFFFD, 16'h0005, 1'b1, 1'b1, 40'hFF_FFFF_FFF1, 1'b0};
        tbl[2]  = '{16'h0007, 16'h0002, 1'b1, 1'b0, 40'hFF_FFFF_FFFF, 1'b0};
        tbl[3]  = '{16'h8000, 16'h8000, 1'b1, 1'b1, 40'h00_4000_0000, 1'b0};
        tbl[4]  = '{16'h7FFF, 16'h8000, 1'b1, 1'b0, 40'h00_0000_8000, 1'b0};
        tbl[5]  = '{16'h1234, 16'h0002, 1'b0, 1'b1, 40'h00_0000_2468, 1'b0};
        tbl[6]  = '{16'h0001, 16'h0001, 1'b0, 1'b0, 40'h00_0000_2469, 1'b0};
        tbl[7]  = '{16'h0000, 16'h8000, 1'b1, 1'b1, 40'h00_0000_0000, 1'b0};
        tbl[8]  = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 40'h00_0000_FFFF, 1'b0};
        tbl[9]  = '{16'hFFFF, 16'h0001, 1'b1, 1'b0, 40'h00_0000_FFFE, 1'b0};
        tbl[10] = '{16'h00FF, 16'h0100, 1'b0, 1'b1, 40'h00_0000_FF00, 1'b0};

        rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0;
        in_signed = 1'b0; in_clr = 1'b0; out_ready = 1'b1;
        #2;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_acc", out_acc, 0);
        check("rst_out_ovf", out_ovf, 0);
        check("rst_in_ready", in_ready, 1);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Latency: beat presented, out_valid after exactly three rising edges.
        @(posedge clk); #1;
        in_a = 16'hFFFF; in_b = 16'hFFFF; in_signed = 1'b0; in_clr = 1'b1; in_valid = 1'b1;
        lat = 0;
        @(posedge clk); #1 in_valid = 1'b0; lat = 1;
        while (!out_valid && lat < 10) begin
            @(posedge clk); #1 lat++;
        end
        check("latency", lat, 3);
        check("lat_acc", out_acc, 40'h00_FFFE_0001);
        check("lat_ovf", out_ovf, 0);
        @(posedge clk); #1;
        check("lat_no_dup", out_valid, 0);

        // Table vectors back-to-back at full throughput.
        for (int i = 0; i < 11; i++) begin
            cur_has_tbl = 1; cur_tacc = tbl[i].exp_acc; cur_tovf = tbl[i].exp_ovf;
            in_a = tbl[i].a; in_b = tbl[i].b; in_signed = tbl[i].sg; in_clr = tbl[i].cl;
            in_valid = 1'b1;
            @(posedge clk); #1;
        end
        in_valid = 1'b0; cur_has_tbl = 0;
        drain();

        // Backpressure: four beats while the output is held off.
        out_ready = 1'b0;
        fork
            begin
                send_beat(16'd100, 16'd3, 1'b0, 1'b1);
                send_beat(16'd2,   16'd2, 1'b0, 1'b0);
                send_beat(16'hFFFF, 16'd1, 1'b1, 1'b0);
                send_beat(16'd10,  16'd10, 1'b0, 1'b0);
            end
            begin
                repeat (6) @(posedge clk);
                @(negedge clk);
                check("bp_in_ready_low", in_ready, 0);
                check("bp_out_valid_held", out_valid, 1);
                check("bp_first_acc", out_acc, 40'd300);
                @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain();

        // Random traffic with random backpressure.
        rnd_done = 0;
        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    send_beat(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)),
                              (i == 0) || ($urandom_range(0, 3) == 0));
                end
                rnd_done = 1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk);
                    #1 out_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        out_ready = 1'b1;
        drain();

        // Saturate vs wrap at a 32-bit accumulator.
        sat_q.delete(); wrap_q.delete(); sat_ovf_q.delete(); wrap_ovf_q.delete();
        sat_exp  = '{32'hFFFE0001, 32'hFFFFFFFF, 32'hFFFE0001, 32'h40000000,
                     32'h7FFFFFFF, 32'hC0008000, 32'h80010000, 32'h80000000};
        sat_oexp = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        wrap_exp = '{32'hFFFE0001, 32'hFFFC0002, 32'hFFFE0001, 32'h40000000,
                     32'h80000000, 32'hC0008000, 32'h80010000, 32'h40018000};
        wrap_oexp = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        send_beat(16'hFFFF, 16'hFFFF, 1'b0, 1'b1);
        send_beat(16'hFFFF, 16'hFFFF, 1'b0, 1'b0);
        send_beat(16'hFFFF, 16'hFFFF, 1'b0, 1'b1);
        send_beat(16'h8000, 16'h8000, 1'b1, 1'b1);
        send_beat(16'h8000, 16'h8000, 1'b1, 1'b0);
        send_beat(16'h7FFF, 16'h8000, 1'b1, 1'b1);
        send_beat(16'h7FFF, 16'h8000, 1'b1, 1'b0);
        send_beat(16'h7FFF, 16'h8000, 1'b1, 1'b0);
        drain();
        check("sat_count", sat_q.size(), 8);
        check("wrap_count", wrap_q.size(), 8);
        for (int i = 0; i < 8; i++) begin
            if (i < sat_q.size()) begin
                check($sformatf("sat_acc[%0d]", i), sat_q[i], sat_exp[i]);
                check($sformatf("sat_ovf[%0d]", i), sat_ovf_q[i], sat_oexp[i]);
            end
            if (i < wrap_q.size()) begin
                check($sformatf("wrap_acc[%0d]", i), wrap_q[i], wrap_exp[i]);
                check($sformatf("wrap_ovf[%0d]", i), wrap_ovf_q[i], wrap_oexp[i]);
            end
        end

        // Reset with three beats in flight.
        send_beat(16'd5, 16'd5, 1'b0, 1'b1);
        send_beat(16'd6, 16'd6, 1'b0, 1'b0);
        send_beat(16'd7, 16'd7, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_out_acc", out_acc, 0);
        check("mid_rst_out_ovf", out_ovf, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        stale = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (out_valid) stale++;
        end
        check("post_rst_stale", stale, 0);
        check("post_rst_in_ready", in_ready, 1);

        // Accumulator restarts from zero after reset.
        send_beat(16'd3, 16'd4, 1'b0, 1'b0);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Hard time limit so the bench can never hang.
    initial begin
        #200000;
        $display("FAIL global_timeout: got=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
